// File: rtl/mat_mult_core.sv
// -----------------------------------------------------------------------------
// mat_mult_core
//
// Sequential unsigned matrix multiplier, C = A x B, for square N x N matrices
// of DW-bit elements. A single multiply-accumulate datapath is time-shared
// across every output element: each element takes N accumulate cycles and one
// write cycle, so a full run keeps busy high for N*N*(N+1) cycles.
//
// Parameters
//   N   matrix dimension (N >= 2)
//   DW  element width in bits
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears mat_C, flags and all state
//   start  level run request, sampled only in IDLE; must fall before re-arm
//   mat_A  operand A, row-major, element (r,c) at r*N+c; held stable while busy
//   mat_B  operand B, same layout
//   mat_C  result register array, same layout, updated one element per write
//   busy   high while a run is in progress
//   done   single-cycle pulse in the cycle after the last element is written
//
// Build option
//   MAT_MULT_SATURATE_EN  when defined, results above 2^DW-1 clamp to 2^DW-1;
//                         otherwise results are truncated modulo 2^DW.
// -----------------------------------------------------------------------------
module mat_mult_core #(
    parameter int N  = 32,
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N*N-1:0][DW-1:0] mat_A,
    input  logic [N*N-1:0][DW-1:0] mat_B,
    output logic [N*N-1:0][DW-1:0] mat_C,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N*N);
    localparam int PW = 2*DW;
    // N products of at most (2^DW-1)^2 each fit in 2*DW+clog2(N) bits.
    localparam int AW = 2*DW + $clog2(N);

    localparam logic [CW-1:0] LAST = CW'(N-1);
    localparam logic [IW-1:0] NIDX = IW'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DONE,
        S_REARM
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            i_q;
    logic [CW-1:0]            j_q;
    logic [CW-1:0]            k_q;
    logic [AW-1:0]            acc_q;
    logic [N*N-1:0][DW-1:0]   mat_c_q;
    logic                     busy_q;
    logic                     done_q;

    logic [IW-1:0]            a_idx;
    logic [IW-1:0]            b_idx;
    logic [IW-1:0]            c_idx;
    logic [PW-1:0]            prod_d;
    logic [AW-1:0]            acc_d;
    logic [DW-1:0]            res_d;

    // ------------------------------------------------------------------
    // Datapath: operand selection, product, accumulate, result format
    // ------------------------------------------------------------------
    always_comb begin
        a_idx  = IW'(i_q) * NIDX + IW'(k_q);
        b_idx  = IW'(k_q) * NIDX + IW'(j_q);
        c_idx  = IW'(i_q) * NIDX + IW'(j_q);
        prod_d = PW'(mat_A[a_idx]) * PW'(mat_B[b_idx]);
        acc_d  = acc_q + AW'(prod_d);
    end

    always_comb begin
`ifdef MAT_MULT_SATURATE_EN
        res_d = (acc_q > AW'({DW{1'b1}})) ? '1 : acc_q[DW-1:0];
`else
        res_d = acc_q[DW-1:0];
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM with registered busy/done and the result array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            mat_c_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_MAC;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_MAC: begin
                    acc_q <= acc_d;
                    if (k_q == LAST) begin
                        state_q <= S_WRITE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end

                S_WRITE: begin
                    mat_c_q[c_idx] <= res_d;
                    acc_q          <= '0;
                    k_q            <= '0;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            // Final element: busy falls and done rises together.
                            i_q     <= '0;
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            i_q     <= i_q + 1'b1;
                            state_q <= S_MAC;
                        end
                    end else begin
                        j_q     <= j_q + 1'b1;
                        state_q <= S_MAC;
                    end
                end

                S_DONE: begin
                    // A start still high here must be released before another run.
                    state_q <= start ? S_REARM : S_IDLE;
                end

                S_REARM: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mat_C = mat_c_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mat_mult_core.sv
module tb_mat_mult_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=2 instance
    logic              rst_n2, start2;
    logic [3:0][7:0]   A2, B2, C2;
    logic              busy2, done2;

    // N=32 instance
    logic              rst_n32, start32;
    logic [1023:0][7:0] A32, B32, C32;
    logic              busy32, done32;

    int checks = 0;
    int errors = 0;

    mat_mult_core #(.N(2), .DW(8)) dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .start (start2),
        .mat_A (A2),
        .mat_B (B2),
        .mat_C (C2),
        .busy  (busy2),
        .done  (done2)
    );

    mat_mult_core #(.N(32), .DW(8)) dut32 (
        .clk   (clk),
        .rst_n (rst_n32),
        .start (start32),
        .mat_A (A32),
        .mat_B (B32),
        .mat_C (C32),
        .busy  (busy32),
        .done  (done32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fmt8(input int unsigned s);
`ifdef MAT_MULT_SATURATE_EN
        return (s > 255) ? 8'd255 : 8'(s);
`else
        return 8'(s % 256);
`endif
    endfunction

    // Reference: textbook row-by-column dot products.
    function automatic logic [3:0][7:0] model2(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
        logic [3:0][7:0] r;
        for (int row = 0; row < 2; row++) begin
            for (int col = 0; col < 2; col++) begin
                int unsigned s;
                s = 0;
                for (int m = 0; m < 2; m++) begin
                    s += int'(a[row*2+m]) * int'(b[m*2+col]);
                end
                r[row*2+col] = fmt8(s);
            end
        end
        return r;
    endfunction

    task automatic randomize2();
        for (int e = 0; e < 4; e++) begin
            A2[e] = 8'($urandom);
            B2[e] = 8'($urandom);
        end
    endtask

    // Called at posedge+1 with the N=2 core idle. Raises start, lets the next
    // edge launch the run, and counts busy cycles until busy falls.
    task automatic run2(input bit hold, input bit probe,
                        input logic [3:0][7:0] exp_new, input logic [3:0][7:0] exp_old,
                        output int bcnt, output int dcnt);
        start2 = 1'b1;
        @(posedge clk); #1;
        if (!hold) start2 = 1'b0;
        bcnt = 0;
        dcnt = 0;
        while (busy2 === 1'b1 && bcnt < 100) begin
            if (done2 === 1'b1) dcnt++;
            if (probe && bcnt == 3)
                chk("progressive_C", {48'd0, C2[3], C2[0]}, {48'd0, exp_old[3], exp_new[0]});
            bcnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [3:0][7:0] exp2, prev2;
        int bcnt, dcnt, cnt, mism;

        rst_n2 = 1'b0; rst_n32 = 1'b0;
        start2 = 1'b0; start32 = 1'b0;
        randomize2();
        for (int e = 0; e < 1024; e++) begin
            A32[e] = 8'($urandom);
            B32[e] = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_C2", C2, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        chk("rst_C32_nonzero", (C32 != '0), 0);
        chk("rst_busy32", busy32, 0);
        rst_n2 = 1'b1; rst_n32 = 1'b1;

        cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy2 !== 1'b0 || done2 !== 1'b0) cnt++;
        end
        chk("idle_activity", cnt, 0);
        chk("idle_C2", C2, 0);

        // Basic product
        A2[0] = 8'd1; A2[1] = 8'd2; A2[2] = 8'd3; A2[3] = 8'd4;
        B2[0] = 8'd5; B2[1] = 8'd6; B2[2] = 8'd7; B2[3] = 8'd8;
        run2(1'b0, 1'b0, '0, '0, bcnt, dcnt);
        chk("basic_busy_len", bcnt, 12);
        chk("basic_done_early", dcnt, 0);
        chk("basic_done_pulse", done2, 1);
        chk("basic_C", C2, {8'd50, 8'd43, 8'd22, 8'd19});
        @(posedge clk); #1;
        chk("basic_done_drop", done2, 0);
        prev2 = C2;

        // Overflow
        A2 = {4{8'd255}};
        B2 = {4{8'd255}};
        run2(1'b0, 1'b0, '0, '0, bcnt, dcnt);
        chk("ovf_busy_len", bcnt, 12);
`ifdef MAT_MULT_SATURATE_EN
        chk("ovf_C", C2, {4{8'd255}});
`else
        chk("ovf_C", C2, {4{8'd2}});
`endif
        @(posedge clk); #1;
        prev2 = model2(A2, B2);

        // Random products; one run also checks not-yet-rewritten elements
        for (int t = 0; t < 4; t++) begin
            randomize2();
            exp2 = model2(A2, B2);
            run2(1'b0, (t == 1), exp2, prev2, bcnt, dcnt);
            chk("rand_busy_len", bcnt, 12);
            chk("rand_C", C2, exp2);
            @(posedge clk); #1;
            prev2 = exp2;
        end

        // Stuck start
        randomize2();
        run2(1'b1, 1'b0, '0, '0, bcnt, dcnt);
        chk("stuck_busy_len", bcnt, 12);
        chk("stuck_done_pulse", done2, 1);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (busy2 !== 1'b0 || done2 !== 1'b0) cnt++;
        end
        chk("stuck_no_rerun", cnt, 0);
        start2 = 1'b0;
        @(posedge clk); #1;
        randomize2();
        exp2 = model2(A2, B2);
        run2(1'b0, 1'b0, '0, '0, bcnt, dcnt);
        chk("rearm_busy_len", bcnt, 12);
        chk("rearm_C", C2, exp2);
        @(posedge clk); #1;

        // Reset mid-run during the third element's accumulate phase
        randomize2();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_before", busy2, 1);
        rst_n2 = 1'b0;
        #1;
        chk("mid_rst_C", C2, 0);
        chk("mid_rst_busy", busy2, 0);
        @(posedge clk); #1;
        rst_n2 = 1'b1;
        @(posedge clk); #1;
        randomize2();
        exp2 = model2(A2, B2);
        run2(1'b0, 1'b0, '0, '0, bcnt, dcnt);
        chk("post_rst_busy_len", bcnt, 12);
        chk("post_rst_C", C2, exp2);

        // Identity, N=32
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                A32[r*32+c] = (r == c) ? 8'd1 : 8'd0;
        @(posedge clk); #1;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        bcnt = 0;
        dcnt = 0;
        while (busy32 === 1'b1 && bcnt < 40000) begin
            if (done32 === 1'b1) dcnt++;
            bcnt++;
            @(posedge clk); #1;
        end
        chk("ident_busy_len", bcnt, 33792);
        chk("ident_done_pulse", done32, 1);
        repeat (5) begin
            if (done32 === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        chk("ident_done_count", dcnt, 1);
        mism = 0;
        for (int e = 0; e < 1024; e++)
            if (C32[e] !== B32[e]) mism++;
        chk("ident_C_mismatches", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_mult_core.md
# mat_mult_core

Sequential unsigned matrix-multiply engine that computes C = A × B on square N×N byte matrices. It sits directly downstream of the memory-mapped accelerator front end: it consumes that block's operand arrays and start flag, and returns the result array the front end exposes for readback. One multiply-accumulate (MAC) unit is time-shared across all output elements, so area stays small and latency scales with N³.

## Interface
- `N`, default 32: matrix dimension; N×N elements per matrix, N ≥ 2.
- `DW`, default 8: element width in bits.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: level request to run. Level-sensitive; see re-arm rule.
- `mat_A` input, [N*N-1:0][DW-1:0]: operand A, row-major, element (r,c) at index r*N+c.
- `mat_B` input, [N*N-1:0][DW-1:0]: operand B, same layout.
- `mat_C` output, [N*N-1:0][DW-1:0]: result register array, same layout.
- `busy` output, 1 bit: high while computing.
- `done` output, 1 bit: one-cycle pulse when the last element is written.

## Operation
- States: IDLE, MAC, WRITE, DONE, REARM.
- IDLE + start=1 → MAC. Clear i, j, k and the accumulator.
- MAC: each cycle, acc += A[i*N+k] * B[k*N+j], then k++. When k==N-1, go to WRITE.
- WRITE: mat_C[i*N+j] <= fmt(acc). Clear acc and k, then advance j. When j wraps, i++.
  - If (i,j)==(N-1,N-1), go to DONE.
  - Otherwise go back to MAC.
- DONE: done=1 for this cycle only.
  - start=0 → IDLE.
  - start=1 → REARM.
- REARM: wait for start=0, then go to IDLE. This prevents a stuck-high start from retriggering a run.
- Operands are unsigned and read live, not snapshotted. Upstream must hold mat_A and mat_B stable while busy=1. Behaviour under operand changes during a run is undefined.
- start is ignored in MAC, WRITE and DONE. There is no abort.
- Widths:
  - product: 2*DW bits
  - accumulator: 2*DW+$clog2(N) bits, which cannot overflow
- fmt() is defined under Configuration.
- mat_C updates progressively, one element per WRITE. Elements not yet rewritten keep their values from the previous run.

## Timing
- Reset values: mat_C all 0, busy=0, done=0, state IDLE, all counters and the accumulator 0.
- Asserting rst_n low mid-run aborts immediately and restores all reset values, including zeroing mat_C.
- Call the edge at which start is sampled high in IDLE edge E0. busy=1 from E0.
- Each element takes N MAC cycles plus 1 WRITE cycle. Busy time is N²(N+1) cycles:
  - N=2: 12 cycles
  - N=32: 33792 cycles
- At edge E_{N²(N+1)} the state becomes DONE. busy=0 and done=1 for exactly that cycle.
- Earliest next start sample is 1 cycle after DONE, and only if start was low in DONE.

## Configuration
- `MAT_MULT_SATURATE_EN` defined: fmt(acc) = 2^DW−1 if acc > 2^DW−1, else acc.
- Not defined: fmt(acc) = acc[DW-1:0], i.e. modulo 2^DW, with no compare logic.

## Test plan
- Reset: hold rst_n=0 with random operands, then release. mat_C all 0, busy=0, done=0, and no activity while start=0.
- Basic product, N=2: A=[1,2;3,4], B=[5,6;7,8], pulse start.
  - busy high exactly 12 cycles.
  - C=[19,22;43,50].
  - done pulses once.
- Overflow, N=2: A and B all 255, so each element's acc = 130050.
  - With MAT_MULT_SATURATE_EN: every C element = 255.
  - Without: every C element = 2.
- Stuck start, N=2: hold start=1 through and after done.
  - No second run; busy stays 0.
  - Drop start for 1 cycle and raise it again: a second run completes in 12 cycles.
- Reset mid-run, N=2: assert rst_n low during the element-3 MAC phase.
  - mat_C immediately all 0 and busy=0.
  - A fresh start then gives the correct result.
- Identity, N=32: A=I, B random.
  - C==B elementwise.
  - busy high exactly 33792 cycles.
  - done asserted exactly once.
